// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int unsigned BCD_W = 4;

    // Number of decimal digits needed to hold the largest magnitude of the input range.
    function automatic int unsigned min_digits(input int unsigned bin_w, input bit signed_mode);
        longint unsigned max_mag;
        int unsigned     n;
        max_mag = signed_mode ? (64'd1 << (bin_w - 1)) : ((64'd1 << bin_w) - 64'd1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_mag >= 64'd10) begin
                max_mag = max_mag / 64'd10;
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit correction cell: add 3 when the digit is 5 or more, before the doubling shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adjusted
);

    always_comb begin
        adjusted = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// valid/ready on both sides and a sticky overflow when DIGITS is too narrow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      sign,
    output logic                      ovf,
    output logic                      busy
);

    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned FIELD_W = BCD_W * DIGITS;

    if (DIGITS < min_digits(BIN_W, SIGNED)) begin : g_narrow
        $warning("bin2bcd_seq: DIGITS=%0d is below the full-range need of %0d; ovf flags losses",
                 DIGITS, min_digits(BIN_W, SIGNED));
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [FIELD_W-1:0] field_q, field_d, field_adj;
    logic               neg_q, neg_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [FIELD_W-1:0] bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (field_q[g*BCD_W +: BCD_W]),
            .adjusted (field_adj[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        field_d   = field_q;
        neg_d     = neg_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    neg_d     = SIGNED && bin[BIN_W-1];
                    mag_d     = (SIGNED && bin[BIN_W-1]) ? (~bin + BIN_W'(1)) : bin;
                    field_d   = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                {field_d, mag_d} = {field_adj[FIELD_W-2:0], mag_q, 1'b0};
                // The bit leaving the top digit is worth 10^DIGITS.
                ovf_acc_d = ovf_acc_q | field_adj[FIELD_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = {field_adj[FIELD_W-2:0], mag_q[BIN_W-1]};
                    ovf_d   = ovf_acc_d;
                    sign_d  = neg_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            field_q   <= '0;
            neg_q     <= 1'b0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            field_q   <= field_d;
            neg_q     <= neg_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bcd  = bcd_q;
    assign sign = sign_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: three 8-bit variants run in lockstep, plus a 16-bit variant with random traffic.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared stimulus for the 8-bit instances.
    logic       in_valid8 = 1'b0;
    logic       out_ready8 = 1'b0;
    logic [7:0] bin8 = '0;

    logic        in_ready_u, out_valid_u, sign_u, ovf_u, busy_u;
    logic [11:0] bcd_u;
    logic        in_ready_s, out_valid_s, sign_s, ovf_s, busy_s;
    logic [11:0] bcd_s;
    logic        in_ready_d, out_valid_d, sign_d, ovf_d, busy_d;
    logic [7:0]  bcd_d;

    logic        in_valid_w = 1'b0;
    logic        out_ready_w = 1'b0;
    logic [15:0] bin_w = '0;
    logic        in_ready_w, out_valid_w, sign_w, ovf_w, busy_w;
    logic [19:0] bcd_w;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_u), .bin(bin8),
        .out_valid(out_valid_u), .out_ready(out_ready8), .bcd(bcd_u), .sign(sign_u),
        .ovf(ovf_u), .busy(busy_u)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_s), .bin(bin8),
        .out_valid(out_valid_s), .out_ready(out_ready8), .bcd(bcd_s), .sign(sign_s),
        .ovf(ovf_s), .busy(busy_s)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u_dut_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready_d), .bin(bin8),
        .out_valid(out_valid_d), .out_ready(out_ready8), .bcd(bcd_d), .sign(sign_d),
        .ovf(ovf_d), .busy(busy_d)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .bin(bin_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .bcd(bcd_w), .sign(sign_w),
        .ovf(ovf_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal reference by repeated division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Accept v on all 8-bit instances and wait for the result; latency must be 8.
    task automatic run8(input logic [7:0] v);
        int n;
        n = 0;
        while (!in_ready_u && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready8 before accept", 64'(in_ready_u), 64'd1);
        bin8 = v;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        chk("busy8 after accept", 64'(busy_u), 64'd1);
        n = 0;
        while (!out_valid_u && n < 40) begin
            tick();
            n++;
        end
        chk("latency8", 64'(n), 64'd8);
    endtask

    task automatic ack8();
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        chk("in_ready8 after ack", 64'(in_ready_u), 64'd1);
        chk("out_valid8 after ack", 64'(out_valid_u), 64'd0);
    endtask

    task automatic expect8(input string tag, input logic [11:0] eu, input logic [11:0] es,
                           input logic esign, input logic [7:0] ed, input logic edovf);
        chk({tag, " u.bcd"}, 64'(bcd_u), 64'(eu));
        chk({tag, " u.sign"}, 64'(sign_u), 64'd0);
        chk({tag, " u.ovf"}, 64'(ovf_u), 64'd0);
        chk({tag, " s.bcd"}, 64'(bcd_s), 64'(es));
        chk({tag, " s.sign"}, 64'(sign_s), 64'(esign));
        chk({tag, " d2.bcd"}, 64'(bcd_d), 64'(ed));
        chk({tag, " d2.ovf"}, 64'(ovf_d), 64'(edovf));
    endtask

    task automatic run16(input logic [15:0] v, input int gap);
        int n;
        n = 0;
        while (!in_ready_w && n < 50) begin
            tick();
            n++;
        end
        bin_w = v;
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        n = 0;
        while (!out_valid_w && n < 60) begin
            tick();
            n++;
        end
        chk("latency16", 64'(n), 64'd16);
        chk("bcd16", 64'(bcd_w), 64'(ref_bcd(32'(v))));
        chk("ovf16", 64'(ovf_w), 64'd0);
        repeat (gap) tick();
        out_ready_w = 1'b1;
        tick();
        out_ready_w = 1'b0;
    endtask

    initial begin
        logic [11:0] held;
        #2;
        chk("reset in_ready", 64'(in_ready_u), 64'd1);
        chk("reset out_valid", 64'(out_valid_u), 64'd0);
        chk("reset busy", 64'(busy_u), 64'd0);
        chk("reset bcd", 64'(bcd_u), 64'd0);
        chk("reset sign", 64'(sign_s), 64'd0);
        chk("reset ovf", 64'(ovf_d), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // out_ready before any result must do nothing.
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        chk("early out_ready", 64'(out_valid_u), 64'd0);

        run8(8'd255); expect8("255", 12'h255, 12'h001, 1'b1, 8'h55, 1'b1); ack8();
        run8(8'd99);  expect8("99",  12'h099, 12'h099, 1'b0, 8'h99, 1'b0); ack8();
        run8(8'd0);   expect8("0",   12'h000, 12'h000, 1'b0, 8'h00, 1'b0); ack8();
        run8(8'h80);  expect8("80h", 12'h128, 12'h128, 1'b1, 8'h28, 1'b1); ack8();
        run8(8'h7F);  expect8("7Fh", 12'h127, 12'h127, 1'b0, 8'h27, 1'b1); ack8();

        // Backpressure: stall in DONE while in_valid pokes at the input.
        run8(8'd63);
        held = bcd_u;
        bin8 = 8'd11;
        in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall out_valid", 64'(out_valid_u), 64'd1);
            chk("stall in_ready", 64'(in_ready_u), 64'd0);
            chk("stall bcd", 64'(bcd_u), 64'h063);
            chk("stall d2.bcd", 64'(bcd_d), 64'h63);
        end
        in_valid8 = 1'b0;
        ack8();
        tick();
        chk("idle holds bcd", 64'(bcd_u), 64'(held));
        chk("idle holds d2", 64'(bcd_d), 64'h63);

        // Reset during the 4th shift cycle.
        bin8 = 8'd77;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrst in_ready", 64'(in_ready_u), 64'd1);
        chk("midrst out_valid", 64'(out_valid_u), 64'd0);
        chk("midrst busy", 64'(busy_u), 64'd0);
        chk("midrst bcd", 64'(bcd_u), 64'd0);
        chk("midrst d2.bcd", 64'(bcd_d), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        run8(8'd200); expect8("200", 12'h200, 12'h056, 1'b1, 8'h00, 1'b1); ack8();

        // 16-bit instance: directed edges then random traffic.
        run16(16'd65535, 0);
        run16(16'd0, 1);
        run16(16'd10000, 2);
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            run16(16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter using shift-and-add-3. Converts a BIN_W-bit unsigned or two's-complement value into DIGITS packed BCD digits plus a sign flag, one bit per clock. Sits between datapath registers and display or text-formatting logic. Uses valid/ready handshakes on both sides and flags any result that does not fit in DIGITS digits.

## Interface
Parameters:
- BIN_W, 8, binary input width; legal range 2..32.
- DIGITS, 3, number of BCD output digits; legal range 1..10.
- SIGNED, 0, input interpretation: 0 = unsigned, 1 = two's complement.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- in_valid  in  1  bin holds a value to convert.
- in_ready  out  1  block can accept a value; high only in IDLE.
- bin  in  BIN_W  input value.
- out_valid  out  1  result registers hold a completed conversion.
- out_ready  in  1  downstream accepts the result.
- bcd  out  4*DIGITS  packed result; digit 0 (ones) in bits [3:0].
- sign  out  1  result is negative; always 0 when SIGNED=0.
- ovf  out  1  magnitude ≥ 10^DIGITS; bcd holds magnitude mod 10^DIGITS.
- busy  out  1  high in SHIFT.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture the magnitude and sign, clear the BCD field, clear ovf, clear the bit counter, then go to SHIFT.
  - SHIFT: each cycle, every digit ≥5 gets +3 (4-bit, no carry between digits). Then {bcd_field, mag} shifts left by 1. If the bit shifted out of the top digit is 1, set the sticky ovf. The counter increments. After the BIN_W-th shift, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Magnitude capture:
  - SIGNED=0: mag = bin.
  - SIGNED=1: sign = bin[BIN_W-1]; mag = sign ? (~bin+1) : bin, held in BIN_W bits unsigned. The most negative value gives magnitude 2^(BIN_W-1), which is exact.
  - Negative zero cannot occur.
- The counter is $clog2(BIN_W+1) bits wide. A terminal count of BIN_W-1 in SHIFT selects DONE.
- bcd, sign and ovf are output registers. They load only on the SHIFT→DONE transition. They stay stable through DONE and remain unchanged in IDLE until the next result loads.
- in_valid is ignored outside IDLE. bin is sampled only on the accept edge.
- Reset from any state, including mid-SHIFT, goes to IDLE immediately. The partial result is discarded.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, bcd=0, sign=0, ovf=0, counter=0.
- Latency: with acceptance at edge E0, shifts occur at edges E1..E_BIN_W. out_valid is high from E_BIN_W, and the result is valid in that same cycle.
- Handshake completes at the edge where out_valid&&out_ready. in_ready rises after that edge; there is no same-cycle re-accept.
- Minimum period per conversion is BIN_W+2 cycles when out_ready is held high.
- out_ready held low stalls indefinitely in DONE. Outputs must not change while stalled.
- out_ready asserted while not out_valid has no effect.

## Structure
- Shared package bin2bcd_pkg provides:
  - state enum {IDLE, SHIFT, DONE};
  - localparam BCD_W=4;
  - function min_digits(bin_w, signed_mode), the digit count needed for the full range.
- An elaboration-time warning fires when DIGITS < min_digits. This is legal and relies on ovf.
- Sub-module bcd_digit_adj: combinational 4-bit "≥5 then +3" cell, instantiated DIGITS times via generate.

## Test plan
- BIN_W=8, DIGITS=3, SIGNED=0, bin=255 accepted at E0 -> out_valid at E8; bcd=12'h255, sign=0, ovf=0. bin=0 -> bcd=12'h000.
- SIGNED=1, BIN_W=8, bin=8'h80 -> sign=1, bcd=12'h128. bin=8'hFF -> sign=1, bcd=12'h001. bin=8'h7F -> sign=0, bcd=12'h127.
- DIGITS=2, bin=255 -> bcd=8'h55, ovf=1. Next conversion of bin=99 -> bcd=8'h99, ovf=0 (sticky cleared).
- Backpressure: out_ready low for 5 cycles after out_valid -> bcd/sign/ovf stable, in_ready=0, new in_valid ignored. out_ready high -> in_ready=1 next cycle.
- rst pulsed during the 4th SHIFT cycle -> immediately in_ready=1, out_valid=0, outputs zeroed. A subsequent conversion of 200 -> bcd=12'h200.
- BIN_W=16, DIGITS=5, random 1000 values with random handshake gaps -> each result matches a reference model, and latency is exactly 16 cycles from accept.
